// File: rtl/l2req_ingress_fifo.sv
// l2req_ingress_fifo: L2-side in-order ingress FIFO for core L2 requests.
// Define L2REQ_INGRESS_BYPASS_EN for a 0-cycle bypass when the FIFO is empty.

package l2req_pkg;

    typedef struct packed {
        logic        valid;
        logic [1:0]  core_id;
        logic [1:0]  unit;
        logic [3:0]  opcode;
        logic        update_lru;
        logic [33:0] addr;
    } l2req_packet_t;

endpackage

module l2req_ingress_fifo
    import l2req_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  l2req_packet_t               l2req_packet,
    output logic                        l2req_ready,
    output l2req_packet_t               pipe_packet,
    input  logic                        pipe_ready,
    output logic [$clog2(FIFO_DEPTH):0] occupancy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    l2req_packet_t mem [FIFO_DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          ready_q;

    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic          rd_en;
    l2req_packet_t head;
    l2req_packet_t wr_data;

    assign fifo_empty = (count == '0);

    // Invalid packets are never accepted, whatever the ready state.
    assign push = l2req_packet.valid && ready_q;

    // Head entry, all-zero while nothing is stored.
    always_comb begin
        head = '0;
        if (!fifo_empty) begin
            head = mem[rd_ptr];
        end
    end

    // Stored entries always carry valid=1; other fields pass through.
    always_comb begin
        wr_data       = l2req_packet;
        wr_data.valid = 1'b1;
    end

`ifdef L2REQ_INGRESS_BYPASS_EN
    logic bypass_hit;

    // Ready is always high at empty, so a bypass hit is also a push.
    assign bypass_hit = fifo_empty && push;

    // Empty FIFO forwards the incoming packet in the same cycle.
    always_comb begin
        pipe_packet = head;
        if (bypass_hit) begin
            pipe_packet = wr_data;
        end
    end

    assign pop   = pipe_packet.valid && pipe_ready;
    assign wr_en = push && !(bypass_hit && pipe_ready);
    assign rd_en = pop && !bypass_hit;
`else
    // Output is driven purely from stored state.
    always_comb begin
        pipe_packet = head;
    end

    assign pop   = pipe_packet.valid && pipe_ready;
    assign wr_en = push;
    assign rd_en = pop;
`endif

    assign count_next = count + CW'(wr_en) - CW'(rd_en);

    // Pointers, count and the registered ready flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_next;
            ready_q <= (count_next < DEPTH_C);
        end
    end

    // Entry storage; contents after reset are don't-care.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign l2req_ready = ready_q;
    assign occupancy   = count;

endmodule

// File: tb/tb_l2req_ingress_fifo.sv
// tb_l2req_ingress_fifo: drives DEPTH 8 and DEPTH 4 instances in lockstep
// and compares both against queue-based reference models every cycle.

module tb_l2req_ingress_fifo;
    import l2req_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pipe_ready = 1'b0;
    l2req_packet_t in_pkt = '0;

    logic          ready8;
    l2req_packet_t pkt8;
    logic [3:0]    occ8;
    logic          ready4;
    l2req_packet_t pkt4;
    logic [2:0]    occ4;

    int checks = 0;
    int errors = 0;

    l2req_packet_t q8[$];
    l2req_packet_t q4[$];
    logic          r8 = 1'b1;
    logic          r4 = 1'b1;

    l2req_ingress_fifo #(.FIFO_DEPTH(8)) u_dut8 (
        .clk          (clk),
        .reset        (reset),
        .l2req_packet (in_pkt),
        .l2req_ready  (ready8),
        .pipe_packet  (pkt8),
        .pipe_ready   (pipe_ready),
        .occupancy    (occ8)
    );

    l2req_ingress_fifo #(.FIFO_DEPTH(4)) u_dut4 (
        .clk          (clk),
        .reset        (reset),
        .l2req_packet (in_pkt),
        .l2req_ready  (ready4),
        .pipe_packet  (pkt4),
        .pipe_ready   (pipe_ready),
        .occupancy    (occ4)
    );

    always #5 clk = ~clk;

    task automatic chk_pkt(input string tag, input l2req_packet_t obs,
                           input l2req_packet_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [7:0] obs,
                           input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic l2req_packet_t mk(input logic v);
        l2req_packet_t p;
        p            = '0;
        p.valid      = v;
        p.core_id    = 2'($urandom);
        p.unit       = 2'($urandom);
        p.opcode     = 4'($urandom);
        p.update_lru = 1'($urandom);
        p.addr       = {2'($urandom), 32'($urandom)};
        return p;
    endfunction

    // What the L2 pipeline should see given the model queue and the input.
    function automatic l2req_packet_t head_of(ref l2req_packet_t q[$]);
        l2req_packet_t h;
        h = '0;
        if (q.size() != 0) begin
            h = q[0];
        end
`ifdef L2REQ_INGRESS_BYPASS_EN
        else if (in_pkt.valid) begin
            h = in_pkt;
        end
`endif
        return h;
    endfunction

    // Apply one clock of push/pop to the model; returns next-cycle ready.
    function automatic logic advance(ref l2req_packet_t q[$], input logic rdy,
                                     input int depth);
        logic          do_push;
        logic          head_v;
        l2req_packet_t p;
        do_push = in_pkt.valid && rdy;
        head_v  = (q.size() != 0);
`ifdef L2REQ_INGRESS_BYPASS_EN
        head_v  = head_v || in_pkt.valid;
`endif
        if (head_v && pipe_ready) begin
            if (q.size() != 0) begin
                void'(q.pop_front());
            end else begin
                do_push = 1'b0;
            end
        end
        if (do_push) begin
            p       = in_pkt;
            p.valid = 1'b1;
            q.push_back(p);
        end
        return (q.size() < depth);
    endfunction

    task automatic step(input string tag);
        #1;
        chk_pkt({tag, ".pkt8"}, pkt8, head_of(q8));
        chk_bit({tag, ".rdy8"}, ready8, r8);
        chk_cnt({tag, ".occ8"}, 8'(occ8), 8'(q8.size()));
        chk_pkt({tag, ".pkt4"}, pkt4, head_of(q4));
        chk_bit({tag, ".rdy4"}, ready4, r4);
        chk_cnt({tag, ".occ4"}, 8'(occ4), 8'(q4.size()));
        r8 = advance(q8, r8, 8);
        r4 = advance(q4, r4, 4);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_pkt({tag, ".pkt8"}, pkt8, '0);
        chk_bit({tag, ".rdy8"}, ready8, 1'b1);
        chk_cnt({tag, ".occ8"}, 8'(occ8), 8'd0);
        chk_pkt({tag, ".pkt4"}, pkt4, '0);
        chk_bit({tag, ".rdy4"}, ready4, 1'b1);
        chk_cnt({tag, ".occ4"}, 8'(occ4), 8'd0);
    endtask

    initial begin
        l2req_packet_t p;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("por");
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            in_pkt = mk(1'b1);
            step("pre");
        end
        in_pkt = '0;

        reset = 1'b1;
        #1;
        chk_reset_vals("arst");
        q8.delete();
        q4.delete();
        r8 = 1'b1;
        r4 = 1'b1;
        reset = 1'b0;
        in_pkt = mk(1'b1);
        step("rel");
        in_pkt = '0;
        step("gotA");
        pipe_ready = 1'b1;
        step("drainA");
        pipe_ready = 1'b0;

        for (int i = 0; i < 8; i++) begin
            p      = mk(1'b1);
            p.addr = 34'(i);
            in_pkt = p;
            step("fill");
        end
        in_pkt = mk(1'b1);
        repeat (3) step("full");
        pipe_ready = 1'b1;
        step("pop1");
        pipe_ready = 1'b0;
        repeat (3) step("held");
        in_pkt = '0;
        pipe_ready = 1'b1;
        repeat (10) step("drain");

        pipe_ready = 1'b0;
        p = mk(1'b0);
        p.opcode = 4'hA;
        in_pkt = p;
        repeat (3) step("inval");

        pipe_ready = 1'b1;
        repeat (20) begin
            in_pkt = mk(1'b1);
            step("stream");
        end
        in_pkt = '0;
        repeat (2) step("sdrain");

        for (int i = 0; i < 1000; i++) begin
            if (i < 500) begin
                in_pkt     = mk($urandom_range(0, 99) < 70);
                pipe_ready = ($urandom_range(0, 99) < 40);
            end else begin
                in_pkt     = mk($urandom_range(0, 99) < 40);
                pipe_ready = ($urandom_range(0, 99) < 70);
            end
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
